idu_stage: RTL

- Registered RV32/RV64 instruction-decode stage for the pipelined NPC core, placed between IFU and EXU.
- Uses valid/ready handshakes on both sides.
- Detects load-use hazards internally and inserts one bubble when needed.
- Latches sticky trap state (ebreak, illegal instruction) in registers instead of calling DPI from combinational logic.

---
 rtl/idu_stage_if.sv | 52 +++++
 rtl/idu_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/idu_stage_if.sv
// Handshake and status bundle around the decode stage: master is the IFU/EXU side, slave is the stage.
interface idu_stage_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_ready;
   logic             out_valid;
   logic [XLEN-1:0]  out_pc;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic             out_reg_wen;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_alu_op;
   logic [1:0]       out_alu_src;
   logic             out_branch;
   logic [2:0]       out_bcond;
   logic             out_jump;
   logic             out_jalr;
   logic             out_mem_ren;
   logic             out_mem_wen;
   logic [1:0]       out_mem_size;
   logic             out_mem_uns;
   logic             out_word_op;
   logic             out_ebreak;
   logic             out_illegal;
   logic             halted;
   logic [31:0]      bad_inst;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] retire_cnt;

   modport master (
      output in_valid, in_inst, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_reg_wen, out_imm,
             out_alu_op, out_alu_src, out_branch, out_bcond, out_jump, out_jalr,
             out_mem_ren, out_mem_wen, out_mem_size, out_mem_uns, out_word_op,
             out_ebreak, out_illegal, halted, bad_inst, stall_cnt, retire_cnt
   );

   modport slave (
      input  in_valid, in_inst, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_reg_wen, out_imm,
             out_alu_op, out_alu_src, out_branch, out_bcond, out_jump, out_jalr,
             out_mem_ren, out_mem_wen, out_mem_size, out_mem_uns, out_word_op,
             out_ebreak, out_illegal, halted, bad_inst, stall_cnt, retire_cnt
   );
endinterface

// File: rtl/idu_stage.sv
// Registered RV32/RV64 decode stage, latency 1; holds its bundle while out_ready is low and
// stalls intake for one bubble on a load-use dependency, or permanently after a trap.
module idu_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   idu_stage_if.slave bus
);
   localparam bit         RV64     = (XLEN == 64);
   localparam logic [2:0] ALU_ADD  = 3'd0, ALU_SUB = 3'd1, ALU_SLTU = 3'd2,
                          ALU_AND  = 3'd3, ALU_SLT = 3'd4;
   localparam logic [1:0] SRC_REG  = 2'd0, SRC_IMM = 2'd1, SRC_PC4 = 2'd2, SRC_IMMPC = 2'd3;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            reg_wen;
      logic [XLEN-1:0] imm;
      logic [2:0]      alu_op;
      logic [1:0]      alu_src;
      logic            branch;
      logic [2:0]      bcond;
      logic            jump;
      logic            jalr;
      logic            mem_ren;
      logic            mem_wen;
      logic [1:0]      mem_size;
      logic            mem_uns;
      logic            word_op;
      logic            ebreak;
      logic            illegal;
   } bundle_t;

   logic [31:0]      w_i;
   logic [6:0]       w_opc;
   logic [2:0]       w_f3;
   logic [6:0]       w_f7;
   logic [31:0]      w_imm32;
   logic             w_ok;
   logic             w_hazard;
   logic             w_in_rdy;
   logic             w_acc;
   bundle_t          w_dec;

   bundle_t          r_bun;
   logic             r_vld;
   logic             r_halted;
   logic             r_ill_seen;
   logic [31:0]      r_bad_inst;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_retire_cnt;

   assign w_i   = bus.in_inst;
   assign w_opc = w_i[6:0];
   assign w_f3  = w_i[14:12];
   assign w_f7  = w_i[31:25];

   always_comb begin
      w_dec    = '0;
      w_ok     = 1'b1;
      w_imm32  = '0;
      w_dec.pc = bus.in_pc;
      case (w_opc)
         7'h33, 7'h3B: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rs2 = w_i[24:20]; w_dec.rd = w_i[11:7];
            w_dec.reg_wen = 1'b1;
            w_dec.word_op = (w_opc == 7'h3B);
            if (w_f3 == 3'd0 && w_f7 == 7'h00)
               w_dec.alu_op = ALU_ADD;
            else if (w_f3 == 3'd0 && w_f7 == 7'h20 && w_opc == 7'h33)
               w_dec.alu_op = ALU_SUB;
            else
               w_ok = 1'b0;
            if (w_opc == 7'h3B && !RV64) w_ok = 1'b0;
         end
         7'h13, 7'h1B: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rd = w_i[11:7];
            w_dec.reg_wen = 1'b1; w_dec.alu_src = SRC_IMM;
            w_dec.word_op = (w_opc == 7'h1B);
            w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            case (w_f3)
               3'd0:    w_dec.alu_op = ALU_ADD;
               3'd2:    w_dec.alu_op = ALU_SLT;
               3'd3:    w_dec.alu_op = ALU_SLTU;
               3'd7:    w_dec.alu_op = ALU_AND;
               default: w_ok = 1'b0;
            endcase
            if (w_opc == 7'h1B && (!RV64 || w_f3 != 3'd0)) w_ok = 1'b0;
         end
         7'h03: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rd = w_i[11:7];
            w_dec.reg_wen = 1'b1; w_dec.mem_ren = 1'b1; w_dec.alu_src = SRC_IMM;
            w_dec.mem_size = w_f3[1:0]; w_dec.mem_uns = w_f3[2];
            w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            // f3=7 never exists; ld and lwu only exist on RV64
            if (w_f3 == 3'd7 || (!RV64 && (w_f3 == 3'd3 || w_f3 == 3'd6))) w_ok = 1'b0;
         end
         7'h23: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rs2 = w_i[24:20];
            w_dec.mem_wen = 1'b1; w_dec.alu_src = SRC_IMM; w_dec.mem_size = w_f3[1:0];
            w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
            if (w_f3[2] || (!RV64 && w_f3 == 3'd3)) w_ok = 1'b0;
         end
         7'h63: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rs2 = w_i[24:20];
            w_dec.branch = 1'b1; w_dec.bcond = w_f3;
            w_imm32 = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
            case (w_f3)
               3'd0, 3'd1: w_dec.alu_op = ALU_SUB;
               3'd4, 3'd5: w_dec.alu_op = ALU_SLT;
               3'd6, 3'd7: w_dec.alu_op = ALU_SLTU;
               default:    w_ok = 1'b0;
            endcase
         end
         7'h6F: begin
            w_dec.rd = w_i[11:7]; w_dec.reg_wen = 1'b1;
            w_dec.jump = 1'b1; w_dec.alu_src = SRC_PC4;
            w_imm32 = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
         end
         7'h67: begin
            w_dec.rs1 = w_i[19:15]; w_dec.rd = w_i[11:7]; w_dec.reg_wen = 1'b1;
            w_dec.jump = 1'b1; w_dec.jalr = 1'b1; w_dec.alu_src = SRC_PC4;
            w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
            if (w_f3 != 3'd0) w_ok = 1'b0;
         end
         7'h37, 7'h17: begin
            w_dec.rd = w_i[11:7]; w_dec.reg_wen = 1'b1;
            w_dec.alu_src = (w_opc == 7'h37) ? SRC_IMM : SRC_IMMPC;
            w_imm32 = {w_i[31:12], 12'h000};
         end
         7'h73: begin
            if (w_i == 32'h0010_0073) w_dec.ebreak = 1'b1;
            else                      w_ok = 1'b0;
         end
         default: w_ok = 1'b0;
      endcase
      w_dec.imm = XLEN'($signed(w_imm32));
      if (w_dec.rd == 5'd0) w_dec.reg_wen = 1'b0;
      if (!w_ok) begin
         w_dec         = '0;
         w_dec.pc      = bus.in_pc;
         w_dec.illegal = 1'b1;
      end
   end

   // unused source fields decode to x0, so they can never match a nonzero load rd
   assign w_hazard = r_vld && r_bun.mem_ren && (r_bun.rd != 5'd0) &&
                     ((w_dec.rs1 == r_bun.rd) || (w_dec.rs2 == r_bun.rd));
   assign w_in_rdy = !r_halted && !bus.flush && !w_hazard && (!r_vld || bus.out_ready);
   assign w_acc    = bus.in_valid && w_in_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld        <= 1'b0;
         r_bun        <= '0;
         r_halted     <= 1'b0;
         r_ill_seen   <= 1'b0;
         r_bad_inst   <= '0;
         r_stall_cnt  <= '0;
         r_retire_cnt <= '0;
      end else begin
         if (r_vld && bus.out_ready) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
         if (bus.flush) begin
            r_vld <= 1'b0;
         end else if (w_acc) begin
            r_vld <= 1'b1;
            r_bun <= w_dec;
            if (w_dec.ebreak || w_dec.illegal) r_halted <= 1'b1;
            if (w_dec.illegal && !r_ill_seen) begin
               r_ill_seen <= 1'b1;
               r_bad_inst <= bus.in_inst;
            end
         end else if (bus.out_ready) begin
            r_vld <= 1'b0;
            if (bus.in_valid && w_hazard && !r_halted) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready     = w_in_rdy;
   assign bus.out_valid    = r_vld;
   assign bus.out_pc       = r_bun.pc;
   assign bus.out_rs1      = r_bun.rs1;
   assign bus.out_rs2      = r_bun.rs2;
   assign bus.out_rd       = r_bun.rd;
   assign bus.out_reg_wen  = r_bun.reg_wen;
   assign bus.out_imm      = r_bun.imm;
   assign bus.out_alu_op   = r_bun.alu_op;
   assign bus.out_alu_src  = r_bun.alu_src;
   assign bus.out_branch   = r_bun.branch;
   assign bus.out_bcond    = r_bun.bcond;
   assign bus.out_jump     = r_bun.jump;
   assign bus.out_jalr     = r_bun.jalr;
   assign bus.out_mem_ren  = r_bun.mem_ren;
   assign bus.out_mem_wen  = r_bun.mem_wen;
   assign bus.out_mem_size = r_bun.mem_size;
   assign bus.out_mem_uns  = r_bun.mem_uns;
   assign bus.out_word_op  = r_bun.word_op;
   assign bus.out_ebreak   = r_bun.ebreak;
   assign bus.out_illegal  = r_bun.illegal;
   assign bus.halted       = r_halted;
   assign bus.bad_inst     = r_bad_inst;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.retire_cnt   = r_retire_cnt;
endmodule
